// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: state encoding and sizing constants.
package div_sequencer_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;
    localparam int RES_W     = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ITER    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divide sequencer: synchronous clear, increment, terminal count.
module div_iter_counter #(
    parameter int ITERS = 32,
    parameter int W     = 6
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(ITERS - 1);

    logic [W-1:0] cnt;

    // Holds at the terminal count instead of wrapping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/div_sequencer.sv
// Sequencer for the iterative divider: latches operands, runs DIV_ITERS iterations, holds the result.
// Optional feature macro: DIV_EARLY_EXC_EN (divide-by-zero completes at the accepting edge).
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DIV_ITERS = div_sequencer_pkg::DIV_ITERS,
    parameter int CNT_W     = div_sequencer_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_DIV,
    input  logic [RES_W-1:0] data_operandA,
    input  logic [RES_W-1:0] data_operandB,
    input  logic [RES_W-1:0] div_result,
    output logic [RES_W-1:0] div_opA,
    output logic [RES_W-1:0] div_opB,
    output logic             div_clr,
    output logic             div_counter_zero,
    output logic [RES_W-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    // Handshake: ctrl_DIV is a pulse sampled every edge with no ready back-pressure;
    // data_resultRDY is a one-cycle valid for data_result/data_exception, which stay held afterwards.

    div_state_t state, state_nxt;
    logic       cnt_clear, cnt_inc, cnt_tc;
    logic       early_exc;
    logic       div_by_zero;

`ifdef DIV_EARLY_EXC_EN
    assign early_exc = ctrl_DIV && (data_operandB == '0);
`else
    assign early_exc = 1'b0;
`endif

    assign div_clr     = ctrl_DIV | ~resetn;
    assign div_by_zero = (div_opB == '0);
    assign dbg_state   = state;

    div_iter_counter #(
        .ITERS (DIV_ITERS),
        .W     (CNT_W)
    ) u_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_clear        = 1'b0;
        cnt_inc          = 1'b0;
        div_counter_zero = 1'b0;
        data_resultRDY   = 1'b0;
        busy             = 1'b0;
        case (state)
            IDLE: ;
            LOAD: begin
                div_counter_zero = 1'b1;
                busy             = 1'b1;
                cnt_clear        = 1'b1;
                state_nxt        = ITER;
            end
            ITER: begin
                busy    = 1'b1;
                cnt_inc = 1'b1;
                if (cnt_tc) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A new request always wins: it aborts whatever is in flight.
        if (ctrl_DIV) begin
            cnt_clear = 1'b1;
            cnt_inc   = 1'b0;
            state_nxt = early_exc ? DONE : LOAD;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_opA <= '0;
            div_opB <= '0;
        end else if (ctrl_DIV) begin
            div_opA <= data_operandA;
            div_opB <= data_operandB;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (early_exc) begin
            data_result    <= '0;
            data_exception <= 1'b1;
        end else if (state == CAPTURE && !ctrl_DIV) begin
            data_result    <= div_by_zero ? '0 : div_result;
            data_exception <= div_by_zero;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: table vectors, hand-written abort/reset/back-to-back sequences, random ops.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] div_result;
    logic [31:0] div_opA, div_opB, data_result;
    logic        div_clr, div_counter_zero, data_exception, data_resultRDY, busy;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;
    vec_t vecs[10];

    div_sequencer dut (
        .clock            (clock),
        .resetn           (resetn),
        .ctrl_DIV         (ctrl_DIV),
        .data_operandA    (data_operandA),
        .data_operandB    (data_operandB),
        .div_result       (div_result),
        .div_opA          (div_opA),
        .div_opB          (div_opB),
        .div_clr          (div_clr),
        .div_counter_zero (div_counter_zero),
        .data_result      (data_result),
        .data_exception   (data_exception),
        .data_resultRDY   (data_resultRDY),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- divider datapath stand-in ----------------
    // Quotient is only presented once a load plus exactly 32 iterations have elapsed.
    logic [5:0]  dp_iter;
    logic        dp_loaded;
    logic [31:0] dp_a, dp_b;

    function automatic logic [31:0] dp_quot(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return 32'($signed(a) / $signed(b));
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dp_iter   <= '0;
            dp_loaded <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
        end else if (div_clr) begin
            dp_iter   <= '0;
            dp_loaded <= 1'b0;
        end else if (div_counter_zero) begin
            dp_iter   <= '0;
            dp_loaded <= 1'b1;
            dp_a      <= div_opA;
            dp_b      <= div_opB;
        end else if (dp_loaded && dp_iter < 6'd40) begin
            dp_iter <= dp_iter + 6'd1;
        end
    end

    assign div_result = (dp_loaded && dp_iter == 6'd32) ? dp_quot(dp_a, dp_b) : 32'hDEAD_BEEF;

    // ---------------- reference model ----------------
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {1'b1, 32'd0};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_EARLY_EXC_EN
        if (b == 32'd0) return 0;
`endif
        return 34;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " div_opA"}, div_opA, 32'd0);
        check({tag, " div_opB"}, div_opB, 32'd0);
        check({tag, " data_result"}, data_result, 32'd0);
        check({tag, " data_exception"}, 32'(data_exception), 32'd0);
        check({tag, " rdy"}, 32'(data_resultRDY), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " counter_zero"}, 32'(div_counter_zero), 32'd0);
        check({tag, " div_clr"}, 32'(div_clr), 32'd1);
        check({tag, " state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Called #1 after an edge; the next edge is edge 0. Returns #1 after edge 0.
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(exp);
        @(posedge clock); #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Counts edges after edge 0 until RDY; busy must be high exactly before the expected RDY edge.
    task automatic wait_rdy(input string name, input int lat);
        int          edges = 0;
        int          busy_err = 0;
        logic [32:0] exp;
        while (data_resultRDY !== 1'b1 && edges < 200) begin
            if (busy !== (edges < lat)) busy_err++;
            @(posedge clock); #1;
            edges++;
        end
        check({name, " latency"}, 32'(edges), 32'(lat));
        check({name, " busy_profile"}, 32'(busy_err), 32'd0);
        check({name, " busy_at_rdy"}, 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: result seen with no expectation queued", name);
        end else begin
            exp = exp_q.pop_front();
            check({name, " result"}, data_result, exp[31:0]);
            check({name, " exception"}, 32'(data_exception), 32'(exp[32]));
        end
    endtask

    task automatic step_check_idle(input string name);
        @(posedge clock); #1;
        check({name, " rdy_pulse_width"}, 32'(data_resultRDY), 32'd0);
        check({name, " back_to_idle"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          rdy_seen;
        logic [31:0] a, b;

        vecs[0] = '{"100/7",     32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1] = '{"-100/7",    32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0};
        vecs[2] = '{"5/0",       32'd5,          32'd0,          32'd0,          1'b1};
        vecs[3] = '{"8/2",       32'd8,          32'd2,          32'd4,          1'b0};
        vecs[4] = '{"9/3",       32'd9,          32'd3,          32'd3,          1'b0};
        vecs[5] = '{"7/100",     32'd7,          32'd100,        32'd0,          1'b0};
        vecs[6] = '{"-7/-2",     32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          1'b0};
        vecs[7] = '{"max/1",     32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0};
        vecs[8] = '{"1/-1",      32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0};
        vecs[9] = '{"-100/-7",   32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};

        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            drive_op(vecs[i].a, vecs[i].b, {vecs[i].exc, vecs[i].res});
            wait_rdy(vecs[i].name, exp_lat(vecs[i].b));
            step_check_idle(vecs[i].name);
        end

        // Restart at edge 12 aborts 100/7; only 9/3 may complete.
        drive_op(32'd100, 32'd7, {1'b0, 32'd14});
        rdy_seen = 0;
        for (int e = 1; e < 12; e++) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check("restart no_early_rdy", 32'(rdy_seen), 32'd0);
        exp_q.delete();
        drive_op(32'd9, 32'd3, {1'b0, 32'd3});
        wait_rdy("restart 9/3", 34);
        step_check_idle("restart");

        // Asynchronous reset in the middle of the iteration phase.
        drive_op(32'd100, 32'd7, {1'b0, 32'd14});
        repeat (10) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;
        drive_op(32'd8, 32'd2, {1'b0, 32'd4});
        wait_rdy("post_reset 8/2", 34);
        step_check_idle("post_reset");

        // New request accepted during DONE of the previous one.
        drive_op(32'd100, 32'd7, {1'b0, 32'd14});
        wait_rdy("b2b first", 34);
        drive_op(32'd8, 32'd2, {1'b0, 32'd4});
        wait_rdy("b2b second", 34);
        step_check_idle("b2b");

        for (int n = 0; n < 16; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 50));
                2:       b = ~32'($urandom_range(0, 49));
                default: b = $urandom;
            endcase
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            drive_op(a, b, ref_div(a, b));
            wait_rdy($sformatf("rand%0d", n), exp_lat(b));
            step_check_idle($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
